// File: rtl/buyruk_onbellegi.sv
// ---------------------------------------------------------------------------
// buyruk_onbellegi : direct-mapped, read-only instruction cache.
//
// A lookup is purely combinational. On a miss the cache refills the whole
// line from memory one 32-bit word per accepted beat. After the refill it
// returns to BOSTA and looks up the current fetch address again.
//
// Parameters
//   SATIR_SAYISI : number of lines (power of two, >= 2)
//   SATIR_KELIME : 32-bit words per line (power of two, >= 2)
//
// Ports
//   clk_i           in   1   clock, rising edge
//   rst_i           in   1   asynchronous active-high reset
//   getir_ps_i      in  32   fetch address (bits [1:0] ignored)
//   getir_gecerli_o out  1   getir_buyruk_o is the word at getir_ps_i
//   getir_buyruk_o  out 32   instruction word (0 when not a hit)
//   gecersiz_kil_i  in   1   pulse: invalidate every line
//   bellek_istek_o  out  1   refill word request
//   bellek_adres_o  out 32   word-aligned refill address (0 when idle)
//   bellek_hazir_i  in   1   memory accepts the request and returns data
//   bellek_veri_i   in  32   refill data, valid with istek && hazir
//
// Memory handshake: a refill beat is transferred in every cycle in which
// bellek_istek_o and bellek_hazir_i are both high. While bellek_hazir_i is
// low, the request and address stay stable.
// ---------------------------------------------------------------------------
module buyruk_onbellegi #(
    parameter int SATIR_SAYISI = 64,
    parameter int SATIR_KELIME = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] getir_ps_i,
    output logic        getir_gecerli_o,
    output logic [31:0] getir_buyruk_o,
    input  logic        gecersiz_kil_i,
    output logic        bellek_istek_o,
    output logic [31:0] bellek_adres_o,
    input  logic        bellek_hazir_i,
    input  logic [31:0] bellek_veri_i
);

    localparam int OFS_W   = $clog2(SATIR_KELIME);
    localparam int IDX_W   = $clog2(SATIR_SAYISI);
    localparam int TAG_LSB = OFS_W + IDX_W + 2;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam int TABAN_W = 32 - OFS_W - 2;

    typedef enum logic {
        BOSTA  = 1'b0,
        DOLDUR = 1'b1
    } durum_t;

    durum_t durum_q, durum_d;

    // Refill context. The line base keeps only the bits above the offset,
    // because the offset and byte bits of the base are always zero.
    logic [OFS_W-1:0]   beat_q;
    logic [TABAN_W-1:0] taban_q;
    logic               kil_gordu_q;  // invalidate seen during this refill

    // Storage. Only the valid bits are reset; they alone gate hits.
    logic [SATIR_SAYISI-1:0] gecerli_q;
    logic [TAG_W-1:0]        etiket_q [SATIR_SAYISI];
    logic [31:0]             veri_q   [SATIR_SAYISI*SATIR_KELIME];

    // Lookup address split
    logic [OFS_W-1:0] ofs;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] etiket;
    logic             unused_bayt;

    assign ofs         = getir_ps_i[2 +: OFS_W];
    assign idx         = getir_ps_i[OFS_W+2 +: IDX_W];
    assign etiket      = getir_ps_i[TAG_LSB +: TAG_W];
    assign unused_bayt = ^getir_ps_i[1:0];

    logic        eslesti;
    logic [31:0] okunan;

    assign eslesti = gecerli_q[idx] && (etiket_q[idx] == etiket);
    assign okunan  = veri_q[{idx, ofs}];

    // Refill target, taken from the latched base
    logic [IDX_W-1:0] dolum_idx;
    logic [TAG_W-1:0] dolum_etiket;
    logic             kabul;
    logic             son_beat;

    assign dolum_idx    = taban_q[0 +: IDX_W];
    assign dolum_etiket = taban_q[IDX_W +: TAG_W];
    assign kabul        = (durum_q == DOLDUR) && bellek_hazir_i;
    assign son_beat     = (beat_q == OFS_W'(SATIR_KELIME - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q <= BOSTA;
        end else begin
            durum_q <= durum_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            BOSTA:   if (!eslesti && !gecersiz_kil_i) durum_d = DOLDUR;
            DOLDUR:  if (kabul && son_beat)           durum_d = BOSTA;
            default: durum_d = BOSTA;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        getir_gecerli_o = 1'b0;
        getir_buyruk_o  = 32'd0;
        bellek_istek_o  = 1'b0;
        bellek_adres_o  = 32'd0;
        case (durum_q)
            BOSTA: begin
                // An invalidate this cycle wins over a hit on a stale line.
                if (eslesti && !gecersiz_kil_i) begin
                    getir_gecerli_o = 1'b1;
                    getir_buyruk_o  = okunan;
                end
            end
            DOLDUR: begin
                bellek_istek_o = 1'b1;
                bellek_adres_o = {taban_q, beat_q, 2'b00};
            end
            default: ;
        endcase
    end

    // ---------------- Refill control and valid bits ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q      <= '0;
            taban_q     <= '0;
            kil_gordu_q <= 1'b0;
            gecerli_q   <= '0;
        end else begin
            if (durum_q == BOSTA && durum_d == DOLDUR) begin
                taban_q     <= getir_ps_i[31:OFS_W+2];
                beat_q      <= '0;
                kil_gordu_q <= 1'b0;
            end
            if (kabul) begin
                beat_q <= beat_q + 1'b1;  // wraps to 0 after the last beat
            end
            if (durum_q == DOLDUR && gecersiz_kil_i) begin
                kil_gordu_q <= 1'b1;
            end
            // An invalidate on any beat, including the last one, leaves the
            // line being filled invalid.
            if (gecersiz_kil_i) begin
                gecerli_q <= '0;
            end else if (kabul && son_beat && !kil_gordu_q) begin
                gecerli_q[dolum_idx] <= 1'b1;
            end
        end
    end

    // ---------------- Tag and data arrays (not reset) ----------------
    always_ff @(posedge clk_i) begin
        if (kabul) begin
            veri_q[{dolum_idx, beat_q}] <= bellek_veri_i;
            if (son_beat) begin
                etiket_q[dolum_idx] <= dolum_etiket;
            end
        end
    end

endmodule

// File: tb/tb_buyruk_onbellegi.sv
// ---------------------------------------------------------------------------
// tb_buyruk_onbellegi : directed, self-checking bench for buyruk_onbellegi
// with default parameters (64 lines x 4 words).
// Inputs change 1 time unit after a rising edge. Outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_buyruk_onbellegi;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] getir_ps_i = 32'd0;
    logic        getir_gecerli_o;
    logic [31:0] getir_buyruk_o;
    logic        gecersiz_kil_i = 1'b0;
    logic        bellek_istek_o;
    logic [31:0] bellek_adres_o;
    logic        bellek_hazir_i = 1'b0;
    logic [31:0] bellek_veri_i = 32'd0;

    int checks = 0;
    int errors = 0;

    buyruk_onbellegi #(
        .SATIR_SAYISI(64),
        .SATIR_KELIME(4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .getir_ps_i     (getir_ps_i),
        .getir_gecerli_o(getir_gecerli_o),
        .getir_buyruk_o (getir_buyruk_o),
        .gecersiz_kil_i (gecersiz_kil_i),
        .bellek_istek_o (bellek_istek_o),
        .bellek_adres_o (bellek_adres_o),
        .bellek_hazir_i (bellek_hazir_i),
        .bellek_veri_i  (bellek_veri_i)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string ad, input logic [31:0] gozlenen,
                       input logic [31:0] beklenen);
        checks++;
        assert (gozlenen === beklenen) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", ad, gozlenen, beklenen);
        end
    endtask

    // Next input slot: 1 unit after the coming rising edge
    task automatic sonraki();
        @(posedge clk_i);
        #1;
    endtask

    // Lookup that is expected to miss: no hit, no request yet
    task automatic iska(input logic [31:0] ps);
        getir_ps_i     = ps;
        bellek_hazir_i = 1'b0;
        @(negedge clk_i);
        chk("miss_gecerli", {31'd0, getir_gecerli_o}, 32'd0);
        chk("miss_istek", {31'd0, bellek_istek_o}, 32'd0);
        sonraki();
    endtask

    // Lookup that is expected to hit
    task automatic isabet(input logic [31:0] ps, input logic [31:0] buyruk);
        getir_ps_i     = ps;
        bellek_hazir_i = 1'b0;
        @(negedge clk_i);
        chk("hit_gecerli", {31'd0, getir_gecerli_o}, 32'd1);
        chk("hit_buyruk", getir_buyruk_o, buyruk);
        chk("hit_istek", {31'd0, bellek_istek_o}, 32'd0);
        sonraki();
    endtask

    // One accepted refill beat
    task automatic beat(input logic [31:0] adres, input logic [31:0] veri);
        bellek_hazir_i = 1'b1;
        bellek_veri_i  = veri;
        @(negedge clk_i);
        chk("beat_istek", {31'd0, bellek_istek_o}, 32'd1);
        chk("beat_adres", bellek_adres_o, adres);
        chk("beat_gecerli", {31'd0, getir_gecerli_o}, 32'd0);
        sonraki();
    endtask

    // One refill wait cycle: request held, address unchanged
    task automatic bekle(input logic [31:0] adres);
        bellek_hazir_i = 1'b0;
        bellek_veri_i  = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("wait_istek", {31'd0, bellek_istek_o}, 32'd1);
        chk("wait_adres", bellek_adres_o, adres);
        sonraki();
    endtask

    initial begin
        // ---------------- reset ----------------
        getir_ps_i = 32'h0000_0100;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_gecerli", {31'd0, getir_gecerli_o}, 32'd0);
        chk("rst_istek", {31'd0, bellek_istek_o}, 32'd0);
        chk("rst_adres", bellek_adres_o, 32'd0);
        chk("rst_buyruk", getir_buyruk_o, 32'd0);
        sonraki();
        rst_i = 1'b0;

        // ---------------- cold miss, zero wait: hit on cycle 6 ----------------
        iska(32'h0000_0100);
        beat(32'h0000_0100, 32'h11);
        beat(32'h0000_0104, 32'h22);
        beat(32'h0000_0108, 32'h33);
        beat(32'h0000_010C, 32'h44);
        isabet(32'h0000_0100, 32'h11);

        // ---------------- hit sweep ----------------
        isabet(32'h0000_0104, 32'h22);
        isabet(32'h0000_0108, 32'h33);
        isabet(32'h0000_010C, 32'h44);
        isabet(32'h0000_0103, 32'h11);  // byte bits ignored

        // ---------------- conflict: 0x100 + 64*4*4 = 0x500 ----------------
        iska(32'h0000_0500);
        beat(32'h0000_0500, 32'hA1);
        beat(32'h0000_0504, 32'hA2);
        beat(32'h0000_0508, 32'hA3);
        beat(32'h0000_050C, 32'hA4);
        isabet(32'h0000_0504, 32'hA2);
        iska(32'h0000_0100);
        beat(32'h0000_0100, 32'h11);
        beat(32'h0000_0104, 32'h22);
        beat(32'h0000_0108, 32'h33);
        beat(32'h0000_010C, 32'h44);
        isabet(32'h0000_0108, 32'h33);

        // ---------------- wait states before beat 2 ----------------
        iska(32'h0000_0200);
        beat(32'h0000_0200, 32'hB1);
        beat(32'h0000_0204, 32'hB2);
        bekle(32'h0000_0208);
        bekle(32'h0000_0208);
        bekle(32'h0000_0208);
        beat(32'h0000_0208, 32'hB3);
        beat(32'h0000_020C, 32'hB4);
        isabet(32'h0000_0208, 32'hB3);
        isabet(32'h0000_020C, 32'hB4);
        isabet(32'h0000_0200, 32'hB1);

        // ---------------- invalidate pulsed on beat 1 ----------------
        iska(32'h0000_0300);
        beat(32'h0000_0300, 32'hC1);
        gecersiz_kil_i = 1'b1;
        beat(32'h0000_0304, 32'hC2);
        gecersiz_kil_i = 1'b0;
        beat(32'h0000_0308, 32'hC3);
        beat(32'h0000_030C, 32'hC4);
        iska(32'h0000_0300);  // line left invalid, refill starts again
        beat(32'h0000_0300, 32'hC1);
        beat(32'h0000_0304, 32'hC2);
        beat(32'h0000_0308, 32'hC3);
        beat(32'h0000_030C, 32'hC4);
        isabet(32'h0000_0304, 32'hC2);

        // ---------------- invalidate in BOSTA: no hit, no refill ----------------
        getir_ps_i     = 32'h0000_0300;
        gecersiz_kil_i = 1'b1;
        @(negedge clk_i);
        chk("kil_bosta_gecerli", {31'd0, getir_gecerli_o}, 32'd0);
        sonraki();
        gecersiz_kil_i = 1'b0;
        iska(32'h0000_0300);  // checks istek=0: the invalidate cycle started nothing
        beat(32'h0000_0300, 32'hD1);
        beat(32'h0000_0304, 32'hD2);
        beat(32'h0000_0308, 32'hD3);
        beat(32'h0000_030C, 32'hD4);
        isabet(32'h0000_030C, 32'hD4);

        // ---------------- async reset mid-fill (beat 2) ----------------
        iska(32'h0000_0100);  // invalidated above
        beat(32'h0000_0100, 32'hE1);
        beat(32'h0000_0104, 32'hE2);
        bellek_hazir_i = 1'b1;
        bellek_veri_i  = 32'hE3;
        #2;
        chk("arst_oncesi_istek", {31'd0, bellek_istek_o}, 32'd1);
        chk("arst_oncesi_adres", bellek_adres_o, 32'h0000_0108);
        rst_i = 1'b1;
        #1;
        chk("arst_istek", {31'd0, bellek_istek_o}, 32'd0);
        chk("arst_adres", bellek_adres_o, 32'd0);
        chk("arst_gecerli", {31'd0, getir_gecerli_o}, 32'd0);
        sonraki();
        rst_i = 1'b0;
        iska(32'h0000_0100);
        @(negedge clk_i);
        chk("arst_sonra_istek", {31'd0, bellek_istek_o}, 32'd1);
        chk("arst_sonra_adres", bellek_adres_o, 32'h0000_0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
